// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, oversampled start/data/parity/stop recovery; optional UART_RX_MAJORITY_VOTE_EN
module uart_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      DATA_VALID,
    output logic                      PAR_ERR,
    output logic                      STP_ERR
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                    r_state;
    logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
    logic [BW-1:0]             r_bit_cnt;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic                      r_par_en;
    logic                      r_par_typ;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic                      r_par_fail;
    logic                      r_stp_fail;
    logic                      r_s_mid;

    logic [PRESCALE_WIDTH-1:0] w_p_eff;
    logic [PRESCALE_WIDTH-1:0] w_half;
    logic [PRESCALE_WIDTH-1:0] w_edge_last;
    logic [PRESCALE_WIDTH-1:0] w_edge_decide;
    logic                      w_bit;
    logic                      w_par_exp;

    // Unsupported ratios fall back to 8x so a bad setting still yields a usable receiver
    assign w_p_eff = (PRESCALE == PRESCALE_WIDTH'(16) || PRESCALE == PRESCALE_WIDTH'(32))
                   ? PRESCALE : PRESCALE_WIDTH'(8);

    assign w_half        = r_prescale >> 1;
    assign w_edge_last   = r_prescale - PRESCALE_WIDTH'(1);
    assign w_edge_decide = w_half + PRESCALE_WIDTH'(1);
    assign w_par_exp     = r_par_typ ? ~^r_shift : ^r_shift;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic                      r_s_early;
    logic [PRESCALE_WIDTH-1:0] w_edge_early;

    assign w_edge_early = w_half - PRESCALE_WIDTH'(1);
    // The live line at P/2+1 is the third vote, so the decision edge is the same as the plain build
    assign w_bit = (r_s_early & r_s_mid) | (r_s_early & RX_IN) | (r_s_mid & RX_IN);

    // Capture the early vote sample at P/2-1
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s_early <= 1'b1;
        end else if (r_state != S_IDLE && r_edge_cnt == w_edge_early) begin
            r_s_early <= RX_IN;
        end
    end
`else
    assign w_bit = r_s_mid;
`endif

    // Capture the mid-bit sample at P/2; it is consumed one edge later at P/2+1
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s_mid <= 1'b1;
        end else if (r_state != S_IDLE && r_edge_cnt == w_half) begin
            r_s_mid <= RX_IN;
        end
    end

    // Frame FSM with bit/edge counters, shift register and registered outcome strobes
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_prescale <= PRESCALE_WIDTH'(8);
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_shift    <= '0;
            r_par_fail <= 1'b0;
            r_stp_fail <= 1'b0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            if (r_state != S_IDLE) begin
                r_edge_cnt <= (r_edge_cnt == w_edge_last) ? '0 : r_edge_cnt + PRESCALE_WIDTH'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (!RX_IN) begin
                        // This cycle is edge 0 of the start bit; frame settings are frozen here
                        r_state    <= S_START;
                        r_edge_cnt <= PRESCALE_WIDTH'(1);
                        r_bit_cnt  <= '0;
                        r_prescale <= w_p_eff;
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                        r_par_fail <= 1'b0;
                        r_stp_fail <= 1'b0;
                    end
                end
                S_START: begin
                    if (r_edge_cnt == w_edge_decide && w_bit) begin
                        r_state    <= S_IDLE;
                        r_edge_cnt <= '0;
                    end else if (r_edge_cnt == w_edge_last) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_edge_cnt == w_edge_decide) begin
                        r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                    end
                    if (r_edge_cnt == w_edge_last) begin
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (r_edge_cnt == w_edge_decide && w_bit != w_par_exp) begin
                        r_par_fail <= 1'b1;
                    end
                    if (r_edge_cnt == w_edge_last) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (r_edge_cnt == w_edge_decide && !w_bit) begin
                        r_stp_fail <= 1'b1;
                    end
                    if (r_edge_cnt == w_edge_last) begin
                        // Decision edge precedes the last edge, so both flags are settled here
                        r_state <= S_IDLE;
                        if (!r_par_fail && !r_stp_fail) begin
                            DATA_VALID <= 1'b1;
                            P_DATA     <= r_shift;
                        end else begin
                            PAR_ERR <= r_par_fail;
                            STP_ERR <= r_stp_fail;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] PRESCALE;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;

    always #5 CLK = ~CLK;

    uart_rx dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .PRESCALE  (PRESCALE),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_ERR   (PAR_ERR),
        .STP_ERR   (STP_ERR)
    );

    typedef struct {
        int         t;
        int         t0;
        bit         dv;
        bit         pe;
        bit         se;
        logic [7:0] d;
        bit         pin;
        int         pin_off;
        logic [7:0] pin_d;
        logic [2:0] pin_kind;
    } ev_t;

    ev_t        q[$];
    int         rd = 0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] m_pdata = 8'h00;
    bit         done = 1'b0;
    ev_t        ev;
    bit         e_dv, e_pe, e_se;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle, outputs must match the frame-level expectation
    always @(negedge CLK) begin
        #1;
        e_dv = 1'b0;
        e_pe = 1'b0;
        e_se = 1'b0;
        if (!RST) begin
            rd      = q.size();
            m_pdata = 8'h00;
        end else if (rd < q.size() && q[rd].t == cyc) begin
            ev = q[rd];
            rd++;
            e_dv = ev.dv;
            e_pe = ev.pe;
            e_se = ev.se;
            if (ev.dv) m_pdata = ev.d;
            if (ev.pin) begin
                chk("pin_latency", ev.t - ev.t0, ev.pin_off);
                chk("pin_pdata", int'(P_DATA), int'(ev.pin_d));
                chk("pin_strobes", int'({DATA_VALID, PAR_ERR, STP_ERR}), int'(ev.pin_kind));
            end
        end
        chk("DATA_VALID", int'(DATA_VALID), int'(e_dv));
        chk("PAR_ERR", int'(PAR_ERR), int'(e_pe));
        chk("STP_ERR", int'(STP_ERR), int'(e_se));
        chk("P_DATA", int'(P_DATA), int'(m_pdata));
        if (done) begin
            chk("events_drained", rd, q.size());
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // Drives one frame starting at a negedge; records the expected outcome and its cycle
    task automatic send_frame(input logic [7:0] data, input logic [5:0] prs, input bit pen,
                              input bit ptyp, input bit par_flip, input bit stop_bad,
                              input int spike_bit, input int abort_at, input bit pin,
                              input int pin_off, input logic [7:0] pin_d, input logic [2:0] pin_kind);
        int   p;
        int   n;
        int   k;
        bit   bits[$];
        logic par;
        ev_t  e;
        p   = (prs == 6'd16) ? 16 : (prs == 6'd32) ? 32 : 8;
        par = (ptyp ? ~^data : ^data) ^ par_flip;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (pen) bits.push_back(par);
        bits.push_back(!stop_bad);
        n = bits.size();
        PRESCALE   = prs;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        e.t0       = cyc;
        e.t        = cyc + n * p;
        e.pe       = pen && par_flip;
        e.se       = stop_bad;
        e.dv       = !(e.pe || e.se);
        e.d        = data;
        e.pin      = pin;
        e.pin_off  = pin_off;
        e.pin_d    = pin_d;
        e.pin_kind = pin_kind;
        q.push_back(e);
        k = 0;
        for (int b = 0; b < n; b++) begin
            for (int ec = 0; ec < p; ec++) begin
                if (k == abort_at) begin
                    RST   = 1'b0;
                    RX_IN = 1'b1;
                    repeat (3) @(negedge CLK);
                    RST = 1'b1;
                    return;
                end
                RX_IN = bits[b];
                if (spike_bit >= 0 && b == spike_bit + 1 && ec == p / 2) RX_IN = ~bits[b];
                if (k == 2 * p) begin
                    PRESCALE = 6'($urandom);
                    PAR_EN   = 1'($urandom);
                    PAR_TYP  = 1'($urandom);
                end
                @(negedge CLK);
                k++;
            end
        end
    endtask

    initial begin
        logic [5:0] prs;
        int         r;
        RST      = 1'b0;
        RX_IN    = 1'b1;
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        idle(5);

        send_frame(8'hA5, 6'd8, 0, 0, 0, 0, -1, -1, 1, 80, 8'hA5, 3'b100);
        idle(4);
        send_frame(8'h3C, 6'd16, 1, 0, 0, 0, -1, -1, 1, 176, 8'h3C, 3'b100);
        idle(3);
        send_frame(8'h3C, 6'd16, 1, 1, 1, 0, -1, -1, 1, 176, 8'h3C, 3'b010);
        idle(2);
        send_frame(8'h55, 6'd8, 0, 0, 0, 1, -1, -1, 1, 80, 8'h3C, 3'b001);
        send_frame(8'h0F, 6'd8, 0, 0, 0, 0, -1, -1, 1, 80, 8'h0F, 3'b100);
        idle(3);

        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        idle(16);
        send_frame(8'h81, 6'd8, 0, 0, 0, 0, -1, -1, 1, 80, 8'h81, 3'b100);
        idle(3);

        send_frame(8'h5A, 6'd8, 0, 0, 0, 0, -1, 40, 0, 0, 8'h00, 3'b000);
        idle(5);
        send_frame(8'h99, 6'd8, 0, 0, 0, 0, -1, -1, 1, 80, 8'h99, 3'b100);
        idle(2);
        send_frame(8'h42, 6'd12, 0, 0, 0, 0, -1, -1, 1, 80, 8'h42, 3'b100);
        idle(2);
        send_frame(8'hC3, 6'd32, 1, 1, 0, 1, -1, -1, 1, 352, 8'h42, 3'b001);
        idle(2);
`ifdef UART_RX_MAJORITY_VOTE_EN
        send_frame(8'h6B, 6'd16, 0, 0, 0, 0, 3, -1, 1, 160, 8'h6B, 3'b100);
        idle(2);
`endif

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            prs = (r < 3) ? 6'd8 : (r < 6) ? 6'd16 : (r < 8) ? 6'd32 : 6'($urandom);
            send_frame(8'($urandom), prs, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                       -1, -1, 0, 0, 8'h00, 3'b000);
            idle(int'($urandom_range(0, 3)));
        end

        idle(5);
        done = 1'b1;
        repeat (5) @(negedge CLK);
        $display("FAIL watchdog: compare process did not finish");
        $fatal(1);
    end

endmodule
